cpu_alu_seq: RTL and testbench
==============================

Name: cpu_alu_seq

Overview:
Sequential ALU directly downstream of the CPU register file. It consumes the register file's A/B register taps and computes a result. For ops that write back, it raises a one-cycle write request that the controller routes to the register file's data_in/enable_write. Single-cycle logic/arith ops sit alongside 8-step iterative multiply and divide, with a start/busy/done handshake and a registered flags word.

Parameters:
WIDTH, 8, operand/result width; MUL/DIV iteration count equals WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rega  input  WIDTH  operand A (register file reg 0 tap)
regb  input  WIDTH  operand B (register file reg 1 tap)
op  input  4  opcode, sampled with start
start  input  1  request; accepted only when FSM in IDLE
result  output  WIDTH  registered result (low byte / quotient)
hi  output  WIDTH  registered MUL high byte / DIV remainder
wr_en  output  1  one-cycle write-back request, coincident with done
done  output  1  one-cycle completion pulse
busy  output  1  high while MUL/DIV iterating
flags  output  4  {Z,C,N,V}, registered

Behaviour:
- Reset (async, any state): FSM to IDLE; result, hi, flags, iteration counter = 0; done, wr_en, busy = 0. An in-flight MUL/DIV is aborted with no done.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical), 8 INC A, 9 DEC A, 10 CMP (A-B, flags only), 11 MUL, 12 DIV (A/B unsigned), 13-15 NOP.
- States: IDLE, ITER, DONE.
- IDLE + start, single-cycle op (0-10, 13-15): at the sampling edge, result/flags load and done=1 for exactly the next cycle. Latency 1. FSM stays IDLE.
- IDLE + start, MUL/DIV with B≠0: the sampling edge latches A and B, clears the accumulators and counter, and enters ITER (busy=1).
- ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per edge. On the WIDTH-th ITER edge, result/hi/flags load, state goes to DONE, busy=0, and done=1.
- DONE lasts one cycle, then IDLE. A start present in the DONE cycle is ignored. Done-to-next-accepted-start minimum is 1 cycle.
- MUL/DIV total: done high after the (WIDTH+1)th rising edge, counting the sampling edge as the 1st.
- DIV with B=0: completes as a single-cycle op. result=all-ones, hi=A, V=1, C=0.
- start while busy or in DONE: ignored; operands and op are not re-sampled.
- Operands are latched at the sampling edge. rega/regb changes during ITER have no effect.
- wr_en=done for ops 0-9, 11, 12. wr_en=0 for CMP and NOP.
- hi updates only on MUL/DIV; other ops hold hi.
- Flags update on every done except NOP, which holds flags.
  - Z: result==0. For MUL, Z requires both result and hi zero.
  - N: result[WIDTH-1].
  - C: ADD/INC carry out. SUB/CMP/DEC borrow (1 when A<B, or A==0 for DEC). SHL shifted-out MSB. SHR shifted-out LSB. MUL: hi≠0. All others 0.
  - V: signed overflow for ADD/SUB/CMP/INC/DEC. 1 for DIV by zero. Otherwise 0.
- All arithmetic wraps modulo 2^WIDTH.

Test Plan:
- ADD A=0x7F, B=0x01 -> next cycle: result=0x80, done=1, wr_en=1, flags Z0 C0 N1 V1.
- SUB A=0x10, B=0x20 -> result=0xF0, C=1, N=1, V=0. Then CMP A=0x20, B=0x20 -> Z=1, wr_en=0, result unchanged.
- MUL A=0x13, B=0x11 -> busy high for 8 cycles. Done after 9th edge: result=0x43, hi=0x01, C=1. Change rega mid-ITER: result unaffected.
- DIV A=0xC8, B=0x07 -> done after 9th edge: result=0x1C, hi=0x04, flags 0000. DIV A=0x55, B=0x00 -> next cycle: result=0xFF, hi=0x55, V=1.
- MUL in flight, pulse start with ADD at ITER cycles 3 and at DONE -> both ignored; exactly one done, carrying the MUL result.
- MUL started, rst_n low at ITER cycle 4 -> immediately all outputs 0, no done. After release, ADD 0x02+0x03 -> result=0x05.

Source files
------------

// File: rtl/cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// cpu_alu_seq
//   Sequential ALU sitting directly behind the CPU register file. Single-cycle
//   logic/arithmetic ops complete one cycle after they are accepted. MUL and DIV
//   run WIDTH shift-add / restoring shift-subtract steps. All outputs are
//   registered.
//
// Ports
//   clk    in   system clock, all state on rising edge
//   rst_n  in   asynchronous active-low reset
//   rega   in   operand A (register file reg 0 tap)
//   regb   in   operand B (register file reg 1 tap)
//   op     in   opcode, sampled together with start
//   start  in   request, accepted only while the FSM is idle
//   result out  result (low half of product / quotient)
//   hi     out  high half of product / remainder
//   wr_en  out  one-cycle write-back request, coincident with done
//   done   out  one-cycle completion pulse
//   busy   out  high while MUL/DIV is iterating
//   flags  out  {Z,C,N,V}
// -----------------------------------------------------------------------------
module cpu_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             wr_en,
  output logic             done,
  output logic             busy,
  output logic [3:0]       flags
);

  // Iteration counter must hold 0..WIDTH-1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Opcodes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;

  // Flag word layout is {Z,C,N,V}.
  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    return {z, c, n, v};
  endfunction

  // Signed overflow of a+b: operands agree in sign, result disagrees.
  function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result takes b's sign.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // State registers
  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [3:0]       flags_q,  flags_d;
  logic             done_q,   done_d;
  logic             wr_en_q,  wr_en_d;
  logic             busy_q,   busy_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             is_mul_q, is_mul_d;
  logic [WIDTH-1:0] a_q,      a_d;    // multiplicand (MUL)
  logic [WIDTH-1:0] b_q,      b_d;    // divisor (DIV)
  logic [WIDTH-1:0] acc_q,    acc_d;  // upper product half / partial remainder
  logic [WIDTH-1:0] lo_q,     lo_d;   // multiplier -> low product / dividend -> quotient

  // Single-cycle datapath
  logic [WIDTH:0]   sc_sum_s, sc_diff_s, sc_inc_s, sc_dec_s;
  logic [WIDTH-1:0] sc_result_s, sc_hi_s, sc_zn_val_s;
  logic             sc_c_s, sc_v_s, sc_wr_s, sc_load_flags_s;
  logic [3:0]       sc_flags_s;

  // Iterative datapath
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_acc_s, mul_lo_s;
  logic [WIDTH:0]   div_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_acc_s, div_lo_s;
  logic [WIDTH-1:0] step_acc_s, step_lo_s;
  logic [3:0]       iter_flags_s;
  logic             iter_start_s;

  // Single-cycle op results, computed straight from the live operand taps.
  always_comb begin
    sc_sum_s        = {1'b0, rega} + {1'b0, regb};
    sc_diff_s       = {1'b0, rega} - {1'b0, regb};
    sc_inc_s        = {1'b0, rega} + {1'b0, ONE_W};
    sc_dec_s        = {1'b0, rega} - {1'b0, ONE_W};
    sc_result_s     = result_q;
    sc_hi_s         = hi_q;
    sc_zn_val_s     = result_q;
    sc_c_s          = 1'b0;
    sc_v_s          = 1'b0;
    sc_wr_s         = 1'b1;
    sc_load_flags_s = 1'b1;
    case (op)
      OP_ADD: begin
        sc_result_s = sc_sum_s[WIDTH-1:0];
        sc_c_s      = sc_sum_s[WIDTH];
        sc_v_s      = add_ovf(rega, regb, sc_sum_s[WIDTH-1:0]);
      end
      OP_SUB: begin
        sc_result_s = sc_diff_s[WIDTH-1:0];
        sc_c_s      = sc_diff_s[WIDTH];
        sc_v_s      = sub_ovf(rega, regb, sc_diff_s[WIDTH-1:0]);
      end
      OP_AND: sc_result_s = rega & regb;
      OP_OR:  sc_result_s = rega | regb;
      OP_XOR: sc_result_s = rega ^ regb;
      OP_NOT: sc_result_s = ~rega;
      OP_SHL: begin
        sc_result_s = {rega[WIDTH-2:0], 1'b0};
        sc_c_s      = rega[WIDTH-1];
      end
      OP_SHR: begin
        sc_result_s = {1'b0, rega[WIDTH-1:1]};
        sc_c_s      = rega[0];
      end
      OP_INC: begin
        sc_result_s = sc_inc_s[WIDTH-1:0];
        sc_c_s      = sc_inc_s[WIDTH];
        sc_v_s      = add_ovf(rega, ONE_W, sc_inc_s[WIDTH-1:0]);
      end
      OP_DEC: begin
        sc_result_s = sc_dec_s[WIDTH-1:0];
        sc_c_s      = sc_dec_s[WIDTH];
        sc_v_s      = sub_ovf(rega, ONE_W, sc_dec_s[WIDTH-1:0]);
      end
      OP_CMP: begin
        // Flags from A-B; result register is left alone.
        sc_zn_val_s = sc_diff_s[WIDTH-1:0];
        sc_c_s      = sc_diff_s[WIDTH];
        sc_v_s      = sub_ovf(rega, regb, sc_diff_s[WIDTH-1:0]);
        sc_wr_s     = 1'b0;
      end
      OP_DIV: begin
        // Only reached with B==0: saturate quotient, pass dividend as remainder.
        sc_result_s = ONES_W;
        sc_hi_s     = rega;
        sc_v_s      = 1'b1;
      end
      OP_MUL: begin
        // Never completes here; MUL always takes the iterative path.
        sc_result_s = result_q;
      end
      default: begin
        // NOP: pulse done only, everything else holds.
        sc_wr_s         = 1'b0;
        sc_load_flags_s = 1'b0;
      end
    endcase
    if (op == OP_CMP) begin
      sc_zn_val_s = sc_diff_s[WIDTH-1:0];
    end else begin
      sc_zn_val_s = sc_result_s;
    end
    sc_flags_s = pack_flags(sc_zn_val_s == ZERO_W, sc_c_s, sc_zn_val_s[WIDTH-1], sc_v_s);
  end

  // One MUL shift-add step and one DIV restoring shift-subtract step.
  always_comb begin
    if (lo_q[0]) begin
      mul_sum_s = {1'b0, acc_q} + {1'b0, a_q};
    end else begin
      mul_sum_s = {1'b0, acc_q};
    end
    mul_acc_s = mul_sum_s[WIDTH:1];
    mul_lo_s  = {mul_sum_s[0], lo_q[WIDTH-1:1]};

    div_sh_s  = {acc_q, lo_q[WIDTH-1]};
    div_ge_s  = (div_sh_s >= {1'b0, b_q});
    // After a successful subtract the remainder is below b, so the low bits suffice.
    if (div_ge_s) begin
      div_acc_s = div_sh_s[WIDTH-1:0] - b_q;
    end else begin
      div_acc_s = div_sh_s[WIDTH-1:0];
    end
    div_lo_s  = {lo_q[WIDTH-2:0], div_ge_s};

    if (is_mul_q) begin
      step_acc_s   = mul_acc_s;
      step_lo_s    = mul_lo_s;
      iter_flags_s = pack_flags((mul_lo_s == ZERO_W) && (mul_acc_s == ZERO_W),
                                mul_acc_s != ZERO_W, mul_lo_s[WIDTH-1], 1'b0);
    end else begin
      step_acc_s   = div_acc_s;
      step_lo_s    = div_lo_s;
      iter_flags_s = pack_flags(div_lo_s == ZERO_W, 1'b0, div_lo_s[WIDTH-1], 1'b0);
    end
  end

  // A MUL, or a DIV with a non-zero divisor, goes through ITER.
  always_comb begin
    if (op == OP_MUL) begin
      iter_start_s = 1'b1;
    end else if ((op == OP_DIV) && (regb != ZERO_W)) begin
      iter_start_s = 1'b1;
    end else begin
      iter_start_s = 1'b0;
    end
  end

  // FSM next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && iter_start_s) begin
          state_d  = ST_ITER;
          busy_d   = 1'b1;
          cnt_d    = {CW{1'b0}};
          is_mul_d = (op == OP_MUL);
          a_d      = rega;
          b_d      = regb;
          acc_d    = ZERO_W;
          if (op == OP_MUL) begin
            lo_d = regb;
          end else begin
            lo_d = rega;
          end
        end else if (start) begin
          done_d   = 1'b1;
          wr_en_d  = sc_wr_s;
          result_d = sc_result_s;
          hi_d     = sc_hi_s;
          if (sc_load_flags_s) begin
            flags_d = sc_flags_s;
          end else begin
            flags_d = flags_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        acc_d = step_acc_s;
        lo_d  = step_lo_s;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          wr_en_d  = 1'b1;
          cnt_d    = {CW{1'b0}};
          result_d = step_lo_s;
          hi_d     = step_acc_s;
          flags_d  = iter_flags_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        // start is deliberately ignored for this one cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any in-flight MUL/DIV without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      flags_q  <= 4'd0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      is_mul_q <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      wr_en_q  <= wr_en_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign flags  = flags_q;
  assign done   = done_q;
  assign wr_en  = wr_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_alu_seq
//   Self-checking bench for cpu_alu_seq (WIDTH=8). Directed steps from the test
//   plan followed by random operations, checked against an integer-arithmetic
//   reference model.
// -----------------------------------------------------------------------------
module tb_cpu_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rega, regb;
  logic [3:0] op;
  logic       start;
  logic [7:0] result, hi;
  logic       wr_en, done, busy;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_result = 8'd0;
  logic [7:0] exp_hi     = 8'd0;
  logic [3:0] exp_flags  = 4'd0;
  logic       exp_wr     = 1'b0;

  cpu_alu_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rega   (rega),
    .regb   (regb),
    .op     (op),
    .start  (start),
    .result (result),
    .hi     (hi),
    .wr_en  (wr_en),
    .done   (done),
    .busy   (busy),
    .flags  (flags)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the operation's definition.
  task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, t, sv, r, h, zn;
    bit z, c, n, v, upd;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = int'(exp_result); h = int'(exp_hi);
    c = 1'b0; v = 1'b0; upd = 1'b1; exp_wr = 1'b1;
    zn = -1;
    case (o)
      4'd0: begin t = ua + ub; r = t % 256; c = (t > 255); sv = sa + sb; v = (sv > 127) || (sv < -128); end
      4'd1: begin t = ua - ub; r = (t + 256) % 256; c = (ua < ub); sv = sa - sb; v = (sv > 127) || (sv < -128); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = 255 - ua;
      4'd6: begin t = ua * 2; r = t % 256; c = (t > 255); end
      4'd7: begin r = ua / 2; c = (ua % 2) == 1; end
      4'd8: begin t = ua + 1; r = t % 256; c = (t > 255); v = (sa + 1) > 127; end
      4'd9: begin t = ua - 1; r = (t + 256) % 256; c = (ua == 0); v = (sa - 1) < -128; end
      4'd10: begin
        zn = (ua - ub + 256) % 256; c = (ua < ub); sv = sa - sb;
        v = (sv > 127) || (sv < -128); exp_wr = 1'b0;
      end
      4'd11: begin t = ua * ub; r = t % 256; h = t / 256; c = (h != 0); end
      4'd12: begin
        if (ub == 0) begin r = 255; h = ua; v = 1'b1; end
        else begin r = ua / ub; h = ua % ub; end
      end
      default: begin upd = 1'b0; exp_wr = 1'b0; end
    endcase
    if (zn < 0) zn = r;
    z = (zn == 0) && ((o != 4'd11) || (h == 0));
    n = (zn >= 128);
    if (upd) begin
      exp_result = 8'(r);
      exp_hi     = 8'(h);
      exp_flags  = {z, c, n, v};
    end
  endtask

  // Single-cycle op: accepted at one edge, done for exactly the following cycle.
  task automatic run_single(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; rega = a; regb = b; start = 1'b1;
    model(o, a, b);
    @(negedge clk);
    start = 1'b0; rega = 8'($urandom); regb = 8'($urandom);
    chk1("sc_done", done, 1'b1);
    chk1("sc_wr_en", wr_en, exp_wr);
    chk1("sc_busy", busy, 1'b0);
    chk8("sc_result", result, exp_result);
    chk8("sc_hi", hi, exp_hi);
    chk4("sc_flags", flags, exp_flags);
    @(negedge clk);
    chk1("sc_done_clr", done, 1'b0);
  endtask

  // MUL/DIV: busy for 8 cycles, done after the 9th edge. Operands are scrambled
  // mid-flight; with poke set, ADD starts are pulsed in ITER and in DONE.
  task automatic run_multi(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                           input bit poke);
    @(negedge clk);
    op = o; rega = a; regb = b; start = 1'b1;
    model(o, a, b);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("it_busy", busy, 1'b1);
      chk1("it_done", done, 1'b0);
      rega = 8'($urandom); regb = 8'($urandom);
      if (poke && (i == 2)) begin
        op = 4'd0; start = 1'b1;
      end else begin
        op = 4'($urandom); start = 1'b0;
      end
      @(negedge clk);
    end
    chk1("md_done", done, 1'b1);
    chk1("md_wr_en", wr_en, 1'b1);
    chk1("md_busy", busy, 1'b0);
    chk8("md_result", result, exp_result);
    chk8("md_hi", hi, exp_hi);
    chk4("md_flags", flags, exp_flags);
    if (poke) begin
      op = 4'd0; rega = 8'h01; regb = 8'h01; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk1("md_done_clr", done, 1'b0);
    chk1("md_busy_clr", busy, 1'b0);
    chk8("md_result_hold", result, exp_result);
    chk4("md_flags_hold", flags, exp_flags);
  endtask

  initial begin
    int ndone;
    logic [3:0] o;
    logic [7:0] a, b;

    rst_n = 1'b0; start = 1'b0; op = 4'd0; rega = 8'd0; regb = 8'd0;
    #12;
    chk8("rst_result", result, 8'h00);
    chk8("rst_hi", hi, 8'h00);
    chk4("rst_flags", flags, 4'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_wr_en", wr_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 7F+01: 80, Z0 C0 N1 V1
    run_single(4'd0, 8'h7F, 8'h01);
    chk8("add_const_result", result, 8'h80);
    chk4("add_const_flags", flags, 4'b0011);
    // SUB 10-20, then CMP 20,20
    run_single(4'd1, 8'h10, 8'h20);
    chk8("sub_const_result", result, 8'hF0);
    run_single(4'd10, 8'h20, 8'h20);
    chk8("cmp_result_hold", result, 8'hF0);
    chk1("cmp_z", flags[3], 1'b1);
    // MUL 13*11 with starts poked during ITER and DONE
    run_multi(4'd11, 8'h13, 8'h11, 1'b1);
    chk8("mul_const_result", result, 8'h43);
    chk8("mul_const_hi", hi, 8'h01);
    // DIV C8/07 and DIV by zero
    run_multi(4'd12, 8'hC8, 8'h07, 1'b0);
    chk8("div_const_result", result, 8'h1C);
    chk8("div_const_hi", hi, 8'h04);
    chk4("div_const_flags", flags, 4'b0000);
    run_single(4'd12, 8'h55, 8'h00);
    chk8("div0_const_hi", hi, 8'h55);
    // Boundary single-cycle ops
    run_single(4'd9, 8'h00, 8'h00);
    run_single(4'd9, 8'h80, 8'h00);
    run_single(4'd8, 8'hFF, 8'h00);
    run_single(4'd6, 8'h81, 8'h00);
    run_single(4'd7, 8'h01, 8'h00);
    run_single(4'd14, 8'h00, 8'h00);
    run_multi(4'd11, 8'h00, 8'hFF, 1'b0);

    // Reset in the middle of a MUL
    @(negedge clk);
    op = 4'd11; rega = 8'h13; regb = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_result = 8'd0; exp_hi = 8'd0; exp_flags = 4'd0;
    chk8("arst_result", result, 8'h00);
    chk8("arst_hi", hi, 8'h00);
    chk4("arst_flags", flags, 4'h0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk1("arst_wr_en", wr_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk1("arst_no_done", ndone != 0, 1'b0);
    run_single(4'd0, 8'h02, 8'h03);
    chk8("arst_add_result", result, 8'h05);

    // Random operations against the model
    for (int k = 0; k < 40; k++) begin
      o = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      if ((o == 4'd12) && ($urandom_range(0, 3) == 0)) b = 8'h00;
      if ((o == 4'd11) || ((o == 4'd12) && (b != 8'h00))) begin
        run_multi(o, a, b, 1'($urandom_range(0, 1)));
      end else begin
        run_single(o, a, b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
